neopixel_uart_core: RTL and testbench
=====================================

// Module: neopixel_uart_core
// PURPOSE
//  UART byte receiver (8N1) plus WS2812 "NeoPixel" single-pixel serializer for PMOD LED boards.
//  Host logic uses the RX side to receive colour bytes over serial.
//  Host logic uses the pixel side to send one 24-bit GRB word per handshake onto a single data line.
//  Inter-frame latch (reset) gaps are the caller's job; this block only times bits.
// PARAMETERS
//  CLK_HZ      12_000_000  system clock frequency
//  BAUD        115_200     UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (104 at defaults)
//  T0H_CYC     4           high time of a WS2812 '0' bit, clocks (~0.33 us)
//  T1H_CYC     9           high time of a WS2812 '1' bit, clocks (~0.75 us)
//  TBIT_CYC    15          full WS2812 bit period, clocks (1.25 us); must be > T1H_CYC
// PORTS
//  CLK       in   1  system clock; all logic on posedge
//  RST       in   1  synchronous, active-high reset
//  RX        in   1  asynchronous UART line, idle high
//  rx_byte   out  8  last received byte, held until the next good byte
//  rx_valid  out  1  one-cycle pulse: rx_byte updated
//  wp_valid  in   1  request to send one pixel
//  wp_red    in   8  red intensity, sampled on accept
//  wp_green  in   8  green intensity, sampled on accept
//  wp_blue   in   8  blue intensity, sampled on accept
//  wp_dout   out  1  WS2812 data line
//  wp_busy   out  1  high while a pixel is being shifted
// BEHAVIOUR
//  Reset: rx_byte=0, rx_valid=0, wp_dout=0, wp_busy=0.
//   Both FSMs go to IDLE; any transfer in progress is aborted and wp_dout drops low on the same edge.
//  RX path:
//   - RX passes through a 2-FF synchronizer before use.
//   - FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   - IDLE: a synchronized low starts a count of CLKS_PER_BIT/2. At mid-start, if RX is high (glitch), return to IDLE.
//   - DATA: sample every CLKS_PER_BIT at mid-bit, LSB first.
//   - STOP: sample at mid-stop. If high: rx_byte<=data and rx_valid=1 for exactly one cycle.
//     If low (framing error): discard the byte with no pulse, and wait for RX high before re-arming.
//   - Back-to-back frames with no idle time between them are received without loss.
//  Pixel path:
//   - Handshake: wp_valid is sampled only when wp_busy=0.
//   - On accept, latch {wp_green,wp_red,wp_blue} (GRB, 24 bits). wp_busy=1 from the next cycle.
//   - wp_valid while busy is ignored, including a held-high valid. A new accept needs valid sampled with busy=0.
//   - Bits go MSB first: G[7] first, B[0] last.
//   - Each bit lasts TBIT_CYC clocks. wp_dout is high for T1H_CYC ('1') or T0H_CYC ('0') from the bit start, then low for the rest.
//   - The first bit's high phase starts the cycle after accept.
//   - wp_busy stays high for exactly 24*TBIT_CYC cycles (360 at defaults), then falls.
//   - wp_dout is low whenever not busy. A new accept is possible the cycle busy reads 0.
//  RX and pixel paths are independent and may run at the same time.
// TESTING
//  - Reset then idle: RX=1 and wp_valid=0 for 1000 cycles -> wp_dout=0, wp_busy=0, rx_valid never pulses.
//  - UART 0xA5 at 115200 (104 clk/bit) -> a single rx_valid pulse about 9.5 bit times after the start edge, with rx_byte=0xA5.
//  - UART frame whose stop bit is 0 -> no rx_valid and rx_byte unchanged; a following good 0x3C is received.
//  - Glitch: RX low for 20 cycles -> no rx_valid.
//  - Pixel R=0x40,G=0x00,B=0x00, valid held 2 cycles -> busy high 360 cycles.
//    Bits 0-8 each show 4 high / 11 low; bit 9 shows 9 high / 6 low. Exactly one transfer occurs.
//  - Pixel G=0xFF,B=0x01 with RST asserted at cycle 100 of the transfer -> next edge: wp_dout=0, wp_busy=0.
//    A new request afterwards starts cleanly.

Source files
------------

// File: rtl/neopixel_uart_core.sv
// 8N1 UART byte receiver plus a WS2812 single-pixel serializer.
// The two paths share only clock and reset.
module neopixel_uart_core #(
  parameter int CLK_HZ   = 12_000_000,
  parameter int BAUD     = 115_200,
  parameter int T0H_CYC  = 4,
  parameter int T1H_CYC  = 9,
  parameter int TBIT_CYC = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       wp_valid,
  input  logic [7:0] wp_red,
  input  logic [7:0] wp_green,
  input  logic [7:0] wp_blue,
  output logic       wp_dout,
  output logic       wp_busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int PW   = $clog2(TBIT_CYC + 1);

  localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [PW-1:0] TBIT_LAST = PW'(TBIT_CYC - 1);
  localparam logic [PW-1:0] T0H       = PW'(T0H_CYC);
  localparam logic [PW-1:0] T1H       = PW'(T1H_CYC);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI
  } rx_state_e;

  typedef enum logic {PX_IDLE, PX_SEND} px_state_e;

  // ---------------- RX path ----------------
  logic            rx_s1_q, rx_s2_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CPB_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CPB_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_byte_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAITHI;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAITHI: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;

  // ---------------- Pixel path ----------------
  px_state_e     px_state_q, px_state_d;
  logic [23:0]   px_sh_q, px_sh_d;
  logic [PW-1:0] px_cyc_q, px_cyc_d;
  logic [4:0]    px_bit_q, px_bit_d;
  logic          px_dout_q, px_dout_d;
  logic [PW-1:0] px_hi;

  always_ff @(posedge CLK) begin
    if (RST) begin
      px_state_q <= PX_IDLE;
      px_sh_q    <= '0;
      px_cyc_q   <= '0;
      px_bit_q   <= '0;
      px_dout_q  <= 1'b0;
    end else begin
      px_state_q <= px_state_d;
      px_sh_q    <= px_sh_d;
      px_cyc_q   <= px_cyc_d;
      px_bit_q   <= px_bit_d;
      px_dout_q  <= px_dout_d;
    end
  end

  always_comb begin
    px_state_d = px_state_q;
    px_sh_d    = px_sh_q;
    px_cyc_d   = px_cyc_q;
    px_bit_d   = px_bit_q;
    unique case (px_state_q)
      PX_IDLE: begin
        if (wp_valid) begin
          px_sh_d    = {wp_green, wp_red, wp_blue};
          px_cyc_d   = '0;
          px_bit_d   = '0;
          px_state_d = PX_SEND;
        end
      end
      PX_SEND: begin
        if (px_cyc_q == TBIT_LAST) begin
          px_cyc_d = '0;
          px_sh_d  = {px_sh_q[22:0], 1'b0};
          px_bit_d = px_bit_q + 1'b1;
          if (px_bit_q == 5'd23) px_state_d = PX_IDLE;
        end else begin
          px_cyc_d = px_cyc_q + 1'b1;
        end
      end
      default: px_state_d = PX_IDLE;
    endcase
    // Data line is registered from next state so it is glitch-free.
    px_hi     = px_sh_d[23] ? T1H : T0H;
    px_dout_d = (px_state_d == PX_SEND) && (px_cyc_d < px_hi);
  end

  assign wp_busy = (px_state_q == PX_SEND);
  assign wp_dout = px_dout_q;

endmodule

// File: tb/tb_neopixel_uart_core.sv
// Directed bench for neopixel_uart_core: UART frames and pixel waveforms.
// All expected values are hand-derived constants or computed from stimulus.
module tb_neopixel_uart_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX  = 1'b1;
  logic       wp_valid = 1'b0;
  logic [7:0] wp_red = '0, wp_green = '0, wp_blue = '0;
  logic [7:0] rx_byte;
  logic       rx_valid, wp_dout, wp_busy;

  neopixel_uart_core dut (
    .CLK(CLK), .RST(RST), .RX(RX),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .wp_valid(wp_valid), .wp_red(wp_red),
    .wp_green(wp_green), .wp_blue(wp_blue),
    .wp_dout(wp_dout), .wp_busy(wp_busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vt = 0;
  logic [7:0] got[$];
  logic wave[0:419];
  logic bsy[0:419];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (rx_valid) begin
      got.push_back(rx_byte);
      vt = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Caller must be at a negedge; returns at a negedge.
  task automatic uart_tx(input logic [7:0] b, input logic stop,
                         output int t0);
    t0 = cyc;
    RX = 1'b0;
    repeat (104) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (104) @(negedge CLK);
    end
    RX = stop;
    repeat (104) @(negedge CLK);
    RX = 1'b1;
  endtask

  task automatic px_run(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input int hold);
    wp_red = r; wp_green = g; wp_blue = b;
    wp_valid = 1'b1;
    for (int i = 0; i < 420; i++) begin
      @(negedge CLK);
      if (i == hold - 1) wp_valid = 1'b0;
      wave[i] = wp_dout;
      bsy[i]  = wp_busy;
    end
  endtask

  task automatic px_check(input string tag, input logic [23:0] w);
    int nb, rises, stray, lead, tot, exp;
    logic prev;
    nb = 0; rises = 0; stray = 0; prev = 1'b0;
    for (int i = 0; i < 420; i++) begin
      if (bsy[i]) nb++;
      if (bsy[i] && !prev) rises++;
      if (!bsy[i] && wave[i]) stray++;
      prev = bsy[i];
    end
    chk({tag, "_busy_cycles"}, nb, 360);
    chk({tag, "_transfers"}, rises, 1);
    chk({tag, "_busy_first"}, {31'd0, bsy[0]}, 1);
    chk({tag, "_busy_end"}, {31'd0, bsy[360]}, 0);
    chk({tag, "_dout_idle"}, stray, 0);
    for (int k = 0; k < 24; k++) begin
      lead = 0; tot = 0;
      for (int j = 0; j < 15; j++) begin
        if (wave[k*15+j]) tot++;
        if (wave[k*15+j] && lead == j) lead++;
      end
      exp = w[23-k] ? 9 : 4;
      chk($sformatf("%s_bit%0d_lead", tag, k), lead, exp);
      chk($sformatf("%s_bit%0d_high", tag, k), tot, exp);
    end
  endtask

  initial begin
    int t0, nv, bad;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_rx_byte", {24'd0, rx_byte}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_dout", {31'd0, wp_dout}, 0);
    chk("rst_busy", {31'd0, wp_busy}, 0);
    RST = 1'b0;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (wp_dout || wp_busy) bad++;
    end
    chk("idle_px", bad, 0);
    chk("idle_rx", got.size(), 0);

    uart_tx(8'hA5, 1'b1, t0);
    repeat (20) @(negedge CLK);
    chk("a5_count", got.size(), 1);
    chk("a5_byte", {24'd0, rx_byte}, 32'hA5);
    chk("a5_lat_ok", {31'd0, (vt - t0 >= 985) && (vt - t0 <= 1000)}, 1);

    nv = got.size();
    uart_tx(8'h55, 1'b0, t0);
    repeat (300) @(negedge CLK);
    chk("ferr_count", got.size(), nv);
    chk("ferr_byte", {24'd0, rx_byte}, 32'hA5);
    uart_tx(8'h3C, 1'b1, t0);
    repeat (20) @(negedge CLK);
    chk("3c_count", got.size(), nv + 1);
    chk("3c_byte", {24'd0, rx_byte}, 32'h3C);

    nv = got.size();
    uart_tx(8'h12, 1'b1, t0);
    uart_tx(8'h34, 1'b1, t0);
    repeat (20) @(negedge CLK);
    chk("b2b_count", got.size(), nv + 2);
    chk("b2b_first", {24'd0, got[nv]}, 32'h12);
    chk("b2b_second", {24'd0, rx_byte}, 32'h34);

    nv = got.size();
    RX = 1'b0;
    repeat (20) @(negedge CLK);
    RX = 1'b1;
    repeat (300) @(negedge CLK);
    chk("glitch_count", got.size(), nv);

    px_run(8'h40, 8'h00, 8'h00, 2);
    px_check("px40", 24'h004000);

    wp_red = 8'h00; wp_green = 8'hFF; wp_blue = 8'h01;
    wp_valid = 1'b1;
    @(negedge CLK);
    wp_valid = 1'b0;
    repeat (99) @(negedge CLK);
    chk("abort_busy_pre", {31'd0, wp_busy}, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_dout", {31'd0, wp_dout}, 0);
    chk("abort_busy", {31'd0, wp_busy}, 0);
    chk("abort_rx_byte", {24'd0, rx_byte}, 0);
    RST = 1'b0;
    @(negedge CLK);

    px_run(8'h80, 8'h00, 8'h00, 1);
    px_check("px80", 24'h008000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
